// File: rtl/uart_pkg.sv
// Shared UART definitions: line levels, frame geometry and receiver FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned UART_CNT_W     = $clog2(UART_DATA_BITS);

  // Line levels shared by transmitter and receiver
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_STOP  = 2'd2,
    ST_BREAK = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Byte FIFO between the receiver shifter and the consumer interface.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       push_i,
  input  uart_byte_t wdata_i,
  input  logic       pop_i,
  output uart_byte_t rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  uart_byte_t      mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            rd_en_c;
  logic            wr_en_c;

  // Accept/advance decisions and next pointer/count values
  always_comb begin
    rd_en_c = pop_i && !empty_q;
    wr_en_c = push_i && (!full_q || rd_en_c);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (wr_en_c) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (rd_en_c) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({wr_en_c, rd_en_c})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CW'(DEPTH));
  end

  // Pointer, count and flag registers
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage; cleared on reset so the head reads as zero while empty
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      mem_q <= '{default: '0};
    end else if (wr_en_c) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: one bit per clock, start + 8 data + stop, bytes buffered in a FIFO.
// After reset or a framing error the line must be seen idle before a start is taken.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      valid,
  input  logic                      ready,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  uart_rx_state_e          state_q, state_d;
  logic [UART_CNT_W-1:0]   cnt_q, cnt_d;
  uart_byte_t              sh_q, sh_d;
  logic                    frame_err_q, frame_err_d;
  logic                    overrun_q, overrun_d;
  logic                    busy_q, busy_d;
  logic                    push_c;
  logic                    pop_c;
  logic                    fifo_full;
  logic                    fifo_empty;

  assign valid = !fifo_empty;
  assign pop_c = valid && ready;

  // Frame FSM, shifter and status pulse generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    push_c      = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx == UART_START_LVL) begin
          state_d = ST_DATA;
          cnt_d   = UART_CNT_W'(UART_DATA_BITS - 1);
        end
      end
      ST_DATA: begin
        if (MSB_FIRST) begin
          sh_d = {sh_q[UART_DATA_BITS-2:0], rx};
        end else begin
          sh_d = {rx, sh_q[UART_DATA_BITS-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - UART_CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (rx == UART_STOP_LVL) begin
          push_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = ST_BREAK;
        end
      end
      ST_BREAK: begin
        if (rx == UART_IDLE_LVL) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_BREAK;
    endcase
    // A full FIFO still takes the byte if the consumer pops in the same cycle
    overrun_d = push_c && fifo_full && !pop_c;
    busy_d    = (state_d == ST_DATA) || (state_d == ST_STOP);
  end

  // State, shifter and registered status outputs
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= ST_BREAK;
      cnt_q       <= '0;
      sh_q        <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

  uart_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .push_i  (push_c),
    .wdata_i (sh_q),
    .pop_i   (pop_c),
    .rdata_o (data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver sitting directly downstream of the UART transmitter: it samples the `rx` line once per `CLK`, the same one-bit-per-clock rate the transmitter uses. It recovers 10-bit frames: a start bit (0), 8 data bits MSB first, and a stop bit (1). Received bytes are buffered in a small FIFO and presented on a valid/ready byte interface. Framing errors and overruns are flagged as one-cycle pulses.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, ≥ 2.
- `MSB_FIRST`, default 1: 1 means the first data bit after start is bit 7; 0 means it is bit 0.
- `CLK` in 1: single clock; all logic is on the rising edge.
- `RESETN` in 1: reset, asynchronous and active-low.
- `rx` in 1: serial line; idles high; one bit per `CLK`.
- `data` out 8: byte at the FIFO head.
- `valid` out 1: FIFO not empty.
- `ready` in 1: consumer accepts `data`; a pop occurs when `valid && ready`.
- `frame_err` out 1: one-cycle pulse; stop bit was sampled 0.
- `overrun` out 1: one-cycle pulse; a good byte was dropped because the FIFO was full.
- `busy` out 1: high in the DATA and STOP states.

## Operation
- FSM states and transitions:
  - IDLE: `rx==0` → DATA with `cnt=7`; otherwise stay in IDLE.
  - DATA: shift `rx` in each cycle, then `cnt<=cnt-1`.
    - `MSB_FIRST=1`: `sh<={sh[6:0],rx}`.
    - `MSB_FIRST=0`: `sh<={rx,sh[7:1]}`.
    - The shift with `cnt==0` is the 8th bit → STOP.
  - STOP, `rx==1`: push `sh` into the FIFO → IDLE.
  - STOP, `rx==0`: assert `frame_err`, discard the byte → BREAK.
  - BREAK: wait for `rx==1` → IDLE. The line must be seen high before any new start bit is accepted.
- Back-to-back frames with a one-cycle stop bit are supported: STOP→IDLE, and the very next cycle may be a start bit.
- `cnt` is 3 bits and never wraps: it is only decremented in DATA, and DATA exits at 0.
- FIFO push rules:
  - A push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and `overrun` pulses.
  - Push and pop in the same cycle leave the count unchanged.
- Pointers are `$clog2(DEPTH)` bits and wrap naturally; count is `$clog2(DEPTH)+1` bits.
- `data` is driven from memory at the read pointer. Memory resets to 0, so `data` is 0 whenever the FIFO is empty after reset. `data` is don't-care when `valid==0`.
- Reset values:
  - FSM in BREAK; `cnt=0`; `sh=0`; FIFO empty.
  - `valid=0`, `data=0`, `frame_err=0`, `overrun=0`, `busy=0`.
  - Reset mid-frame discards the partial byte and all buffered bytes.

## Timing
- Let cycle 0 be the cycle in which IDLE samples the start bit.
  - Data bits are sampled in cycles 1–8.
  - The stop bit is sampled in cycle 9.
  - The byte is written at the end of cycle 9.
  - `valid` is high from cycle 10 if the FIFO was empty.
- `frame_err` and `overrun` are registered and high during cycle 10 only.
- `busy` rises in cycle 1 and falls in cycle 10.
- A pop takes effect at the clock edge. `valid`/`data` reflect the next entry from the following cycle.
- `ready` is sampled only when `valid==1`.
- Frame-to-frame minimum spacing is 10 cycles. Sustained throughput is 1 byte per 10 cycles.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, DATA, STOP, BREAK).
  - `UART_DATA_BITS=8`.
  - Start/stop/idle level constants, to be shared with the transmitter.
- Sub-module `uart_rx_fifo`: synchronous FIFO with parameter DEPTH, 8-bit width, push/pop/full/empty. It uses the same `CLK`/`RESETN`.
- The FSM and shifter live in `uart_rx`.

## Test plan
- Single frame, `ready=1`: `rx`=0,1,0,1,0,0,1,0,1,1 → `valid` high at cycle 10 with `data=0xA5` for one cycle; no error pulses.
- Back-to-back: 0x3C then 0xC3, each with a single stop cycle, `ready=1` → bytes 0x3C and 0xC3 delivered in order, 10 cycles apart.
- Framing:
  - 0x55 with the stop bit held at 0 → `frame_err` pulse at cycle 10, no `valid`.
  - Then hold `rx` low for 5 cycles, then high → no bytes while low.
  - A following frame 0x12 is received correctly.
- Overrun: `ready=0`, `DEPTH=4`, frames 0x01..0x05 → `overrun` pulses after the 5th frame; popping yields 0x01..0x04, then `valid=0`.
- Full with simultaneous pop: FIFO full, `ready=1` for exactly the 5th frame's stop cycle → no `overrun`; pops yield 0x02..0x05.
- Reset and bit order:
  - Assert `RESETN` low during data bit 4 → all outputs 0 immediately.
  - Release while `rx` is low → nothing is received until `rx` goes high.
  - Next frame 0x81 is received.
  - `MSB_FIRST=0` with 0x01 sent LSB first → `data=0x01`.
